// File: rtl/counters_pkg.sv
// Shared definitions for the counters readout slice: main FSM one-hot codes,
// poller FSM states and default widths.
package counters_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } main_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } poll_state_e;

    localparam int DEF_CNT_W = 5;
    localparam int DEF_IDX_W = 3;

endpackage

// File: rtl/counts_poller_if.sv
// Counters readout request/response bus: the poller is master, the counters block is slave.
interface counts_poller_if
    import counters_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             req;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] counts;
    logic             cnt_valid;

    modport master (output req, output idx, input counts, input cnt_valid);
    modport slave  (input req, input idx, output counts, output cnt_valid);
endinterface

// File: rtl/counts_result_bank.sv
// Result bank for polled counts: synchronous write, asynchronous read and clear.
module counts_result_bank #(
    parameter int NUM_CNT = 5,
    parameter int IDX_W   = 3,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data
);

    logic [CNT_W-1:0] mem [NUM_CNT];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(wr_idx) < NUM_CNT)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Addresses past the last counter read as zero.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < NUM_CNT) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: rtl/counts_poller.sv
// Counters readout initiator: sweeps idx 0..NUM_CNT-1 while the main FSM is IDLE.
// Optional COUNTS_CHECK_EN adds exp_counts/mismatch per-counter comparison.
module counts_poller
    import counters_pkg::*;
#(
    parameter int NUM_CNT = 5,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic [3:0]             state,
    input  logic                   start,
    counts_poller_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   abort,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [CNT_W-1:0]       rd_data
`ifdef COUNTS_CHECK_EN
    ,
    input  logic [NUM_CNT*CNT_W-1:0] exp_counts,
    output logic [NUM_CNT-1:0]       mismatch
`endif
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    poll_state_e      fsm, fsm_nxt;
    logic [IDX_W-1:0] idx_r;
    logic [TMR_W-1:0] timer;
    logic             abort_r;
    logic in_idle, sweeping, lost, go, rejected, capture, last_idx, timed_out;

    // Losing the IDLE main state aborts combinationally so req/busy drop in the same cycle.
    always_comb begin
        in_idle   = (state == ST_IDLE);
        sweeping  = (fsm == S_REQ) || (fsm == S_WAIT);
        lost      = sweeping && !in_idle;
        go        = (fsm == S_IDLE) && start && in_idle;
        rejected  = (fsm == S_IDLE) && start && !in_idle;
        capture   = (fsm == S_WAIT) && in_idle && bus.cnt_valid;
        last_idx  = (idx_r == IDX_W'(NUM_CNT - 1));
        timed_out = (fsm == S_WAIT) && in_idle && !bus.cnt_valid
                    && (timer == TMR_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) fsm <= S_IDLE;
        else          fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_IDLE:  if (go) fsm_nxt = S_REQ;
            S_REQ:   fsm_nxt = lost ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (lost || timed_out) fsm_nxt = S_IDLE;
                else if (capture)      fsm_nxt = last_idx ? S_DONE : S_REQ;
            end
            S_DONE:  fsm_nxt = S_IDLE;
            default: fsm_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req = (fsm == S_REQ) && in_idle;
        bus.idx = idx_r;
        busy    = sweeping && in_idle;
        done    = (fsm == S_DONE);
        abort   = abort_r || lost;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            idx_r   <= '0;
            timer   <= '0;
            abort_r <= 1'b0;
        end else begin
            if (go) begin
                idx_r   <= '0;
                abort_r <= 1'b0;
            end
            if (rejected || lost || timed_out) abort_r <= 1'b1;
            if (lost || timed_out) idx_r <= '0;
            if (capture) idx_r <= last_idx ? '0 : idx_r + IDX_W'(1);
            if (fsm == S_REQ)                   timer <= '0;
            else if (fsm == S_WAIT && !capture) timer <= timer + TMR_W'(1);
        end
    end

    counts_result_bank #(
        .NUM_CNT (NUM_CNT),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) u_bank (
        .clk     (clk),
        .reset_L (reset_L),
        .we      (capture),
        .wr_idx  (idx_r),
        .wr_data (bus.counts),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

`ifdef COUNTS_CHECK_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            mismatch <= '0;
        end else if (go) begin
            mismatch <= '0;
        end else if (capture) begin
            mismatch[idx_r] <= (bus.counts != exp_counts[int'(idx_r)*CNT_W +: CNT_W]);
        end
    end
`endif

endmodule

// File: tb/tb_counts_poller.sv
// Self-checking bench for counts_poller: directed sweep table, hand sequences and
// randomized sweeps against a transaction-level timing model.
module tb_counts_poller;
    import counters_pkg::*;

    localparam int NUM = 5, IW = 3, CW = 5, TO = 8, SWEEP_TICKS = 70;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [3:0]    state;
    logic          start;
    logic [IW-1:0] rd_idx;
    logic [CW-1:0] rd_data;
    logic          busy, done, abort;
`ifdef COUNTS_CHECK_EN
    logic [NUM*CW-1:0] exp_counts;
    logic [NUM-1:0]    mismatch;
`endif

    counts_poller_if #(.IDX_W(IW), .CNT_W(CW)) bus ();

    counts_poller #(
        .NUM_CNT (NUM),
        .IDX_W   (IW),
        .CNT_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .state   (state),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .abort   (abort),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
`ifdef COUNTS_CHECK_EN
        ,
        .exp_counts (exp_counts),
        .mismatch   (mismatch)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CW-1:0] vals[NUM];
    int            delays[NUM];
    logic [CW-1:0] ref_bank[NUM];

    bit   pend;
    int   pend_idx, pend_wait;
    int   req_log[$];
    int   obs_done_at, obs_done_cnt, obs_abort_at;
    logic obs_drop_req, obs_drop_busy, obs_done_busy;
    logic [IW-1:0] obs_done_idx;

    typedef struct packed {
        logic [0:4][4:0] v;
        logic [0:4][7:0] d;
        int              drop;
        int              restart;
        int              exp_done;
        int              exp_abort;
        logic [0:4][4:0] bank;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic readback();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_idx = IW'(i);
            #2;
            check($sformatf("rd_data[%0d]", i), rd_data, (i < NUM) ? ref_bank[i] : '0);
        end
    endtask

    // Tick 0 carries the start pulse; the responder answers delays[idx] cycles
    // after the cycle following each req.
    task automatic run_sweep(input int drop, input int restart, input int n_ticks);
        pend = 0;
        req_log.delete();
        obs_done_at = -1; obs_done_cnt = 0; obs_abort_at = -1;
        obs_drop_req = 1'bx; obs_drop_busy = 1'bx;
        for (int t = 0; t < n_ticks; t++) begin
            @(posedge clk);
            #1;
            start = (t == 0) || (t == restart);
            if (t == drop) state = ST_ACTIVE;
            if (pend && pend_wait == 0) begin
                bus.cnt_valid = 1'b1;
                bus.counts    = vals[pend_idx];
                pend          = 0;
            end else begin
                bus.cnt_valid = 1'b0;
                bus.counts    = CW'($urandom);
                if (pend) pend_wait--;
            end
            @(negedge clk);
            if (t == 1 && drop != 1) begin
                check("busy_after_start", busy, 1);
                check("abort_cleared_on_start", abort, 0);
            end
            if (t == drop) begin
                obs_drop_req  = bus.req;
                obs_drop_busy = busy;
            end
            if (bus.req === 1'b1) begin
                req_log.push_back(int'(bus.idx));
                pend      = 1;
                pend_idx  = (int'(bus.idx) < NUM) ? int'(bus.idx) : 0;
                pend_wait = delays[pend_idx];
            end
            if (done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_at < 0) begin
                    obs_done_at   = t;
                    obs_done_busy = busy;
                    obs_done_idx  = bus.idx;
                end
            end
            if (t >= 1 && abort === 1'b1 && obs_abort_at < 0) obs_abort_at = t;
        end
        state         = ST_IDLE;
        start         = 1'b0;
        bus.cnt_valid = 1'b0;
    endtask

    // Timing from the rules: each counter costs 2 + delay cycles, done one cycle
    // after the last capture, timeout TIMEOUT cycles after the wait begins.
    task automatic ref_sweep(input int drop, output int e_done, output int e_abort, output int e_nreq);
        int t;
        t = 1; e_done = -1; e_abort = -1; e_nreq = 0;
        for (int k = 0; k < NUM; k++) begin
            int d, win_end;
            d       = delays[k];
            win_end = (d >= TO) ? t + TO : t + 1 + d;
            if (drop >= t && drop <= win_end) begin
                e_abort = drop;
                if (drop != t) e_nreq++;
                return;
            end
            e_nreq++;
            if (d >= TO) begin
                e_abort = t + TO + 1;
                return;
            end
            ref_bank[k] = vals[k];
            t += 2 + d;
        end
        e_done = t;
    endtask

    task automatic check_sweep(input int e_done, input int e_abort, input int e_nreq, input int drop);
        check("done_at", obs_done_at, e_done);
        check("done_pulses", obs_done_cnt, (e_done >= 0) ? 1 : 0);
        check("abort_at", obs_abort_at, e_abort);
        if (e_done >= 0) begin
            check("busy_at_done", obs_done_busy, 0);
            check("idx_at_done", obs_done_idx, 0);
        end
        if (drop >= 0 && drop == e_abort) begin
            check("req_on_state_drop", obs_drop_req, 0);
            check("busy_on_state_drop", obs_drop_busy, 0);
        end
        if (e_nreq >= 0) check("req_count", req_log.size(), e_nreq);
        foreach (req_log[i]) check("req_idx_order", req_log[i], i);
        readback();
    endtask

    initial begin
        int ed, ea, en, drop, r;
        bit saw_req;

        tbl[0] = '{v: '{5'd3, 5'd0, 5'd7, 5'd31, 5'd12}, d: '0, drop: -1, restart: -1,
                   exp_done: 11, exp_abort: -1, bank: '{5'd3, 5'd0, 5'd7, 5'd31, 5'd12}};
        tbl[1] = '{v: '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5}, d: '{8'd0, 8'd0, 8'd200, 8'd0, 8'd0},
                   drop: -1, restart: -1, exp_done: -1, exp_abort: 14,
                   bank: '{5'd1, 5'd2, 5'd7, 5'd31, 5'd12}};
        tbl[2] = '{v: '{5'd9, 5'd9, 5'd9, 5'd9, 5'd9}, d: '0, drop: 8, restart: -1,
                   exp_done: -1, exp_abort: 8, bank: '{5'd9, 5'd9, 5'd9, 5'd31, 5'd12}};
        tbl[3] = '{v: '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1}, d: '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0},
                   drop: -1, restart: -1, exp_done: -1, exp_abort: 10,
                   bank: '{5'd9, 5'd9, 5'd9, 5'd31, 5'd12}};
        tbl[4] = '{v: '{5'd31, 5'd30, 5'd1, 5'd0, 5'd17}, d: '{8'd1, 8'd3, 8'd7, 8'd0, 8'd2},
                   drop: -1, restart: -1, exp_done: 24, exp_abort: -1,
                   bank: '{5'd31, 5'd30, 5'd1, 5'd0, 5'd17}};
        tbl[5] = '{v: '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9}, d: '0, drop: -1, restart: 4,
                   exp_done: 11, exp_abort: -1, bank: '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9}};

        reset_L = 1'b0; state = ST_IDLE; start = 1'b0; rd_idx = '0;
        bus.cnt_valid = 1'b0; bus.counts = '0;
`ifdef COUNTS_CHECK_EN
        exp_counts = '0;
`endif
        for (int k = 0; k < NUM; k++) ref_bank[k] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req", bus.req, 0);
        check("reset_idx", bus.idx, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_abort", abort, 0);
        readback();
        @(negedge clk);
        reset_L = 1'b1;

        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < NUM; k++) begin
                vals[k]     = tbl[e].v[k];
                delays[k]   = int'(tbl[e].d[k]);
                ref_bank[k] = tbl[e].bank[k];
            end
            run_sweep(tbl[e].drop, tbl[e].restart, SWEEP_TICKS);
            check_sweep(tbl[e].exp_done, tbl[e].exp_abort, -1, tbl[e].drop);
        end

        // cnt_valid while idle must not touch the bank
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            bus.cnt_valid = 1'b1;
            bus.counts    = 5'd17;
        end
        @(posedge clk); #1;
        bus.cnt_valid = 1'b0;
        readback();

        // start outside main IDLE is rejected and flags abort
        @(negedge clk);
        check("abort_before_rejected_start", abort, 0);
        @(posedge clk); #1;
        state = ST_ACTIVE;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        saw_req = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (bus.req === 1'b1) saw_req = 1;
        end
        check("req_after_rejected_start", saw_req, 0);
        check("abort_after_rejected_start", abort, 1);
        check("busy_after_rejected_start", busy, 0);
        state = ST_IDLE;

        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < NUM; k++) begin
                vals[k] = CW'($urandom);
                r = int'($urandom_range(0, 9));
                if (r < 7)      delays[k] = int'($urandom_range(0, 3));
                else if (r < 8) delays[k] = TO - 1;
                else            delays[k] = TO + int'($urandom_range(0, 2));
            end
            drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 30)) : -1;
            run_sweep(drop, -1, SWEEP_TICKS);
            ref_sweep(drop, ed, ea, en);
            check_sweep(ed, ea, en, drop);
        end

`ifdef COUNTS_CHECK_EN
        vals[0] = 5'd3; vals[1] = 5'd0; vals[2] = 5'd6; vals[3] = 5'd31; vals[4] = 5'd12;
        for (int k = 0; k < NUM; k++) delays[k] = 0;
        exp_counts = {5'd12, 5'd31, 5'd7, 5'd0, 5'd3};
        run_sweep(-1, -1, SWEEP_TICKS);
        ref_sweep(-1, ed, ea, en);
        check_sweep(ed, ea, en, -1);
        check("mismatch", mismatch, 5'b00100);
`endif

        // reset in the middle of a sweep
        for (int k = 0; k < NUM; k++) begin
            vals[k]   = CW'(k + 20);
            delays[k] = 0;
        end
        run_sweep(-1, -1, 6);
        reset_L = 1'b0;
        #1;
        check("midrun_reset_req", bus.req, 0);
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_abort", abort, 0);
        check("midrun_reset_done", done, 0);
        for (int k = 0; k < NUM; k++) ref_bank[k] = '0;
        readback();
        reset_L = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
